// File: rtl/ysyx_lsu_pkg.sv
// ysyx_lsu_pkg: select encodings, FSM states, timeout counter width and alignment helper
package ysyx_lsu_pkg;
  localparam logic [2:0] RD_NONE = 3'b000;
  localparam logic [2:0] RD_LB   = 3'b001;
  localparam logic [2:0] RD_LH   = 3'b010;
  localparam logic [2:0] RD_LW   = 3'b011;
  localparam logic [2:0] RD_LBU  = 3'b100;
  localparam logic [2:0] RD_LHU  = 3'b101;
  localparam logic [1:0] WR_NONE = 2'b00;
  localparam logic [1:0] WR_SB   = 2'b01;
  localparam logic [1:0] WR_SH   = 2'b10;
  localparam logic [1:0] WR_SW   = 2'b11;
  localparam int TO_W = 8;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;
  function automatic logic is_mis(input logic [2:0] rd, input logic [1:0] wr, input logic [1:0] a);
    return ((rd == RD_LH || rd == RD_LHU || wr == WR_SH) && a[0]) ||
           ((rd == RD_LW || wr == WR_SW) && a != 2'b00);
  endfunction
endpackage

// File: rtl/ysyx_lsu_align.sv
// ysyx_lsu_align: store lane replication/byte mask and load shift/extend
module ysyx_lsu_align import ysyx_lsu_pkg::*; (
  input  logic [1:0]  a,
  input  logic [2:0]  rd_sel,
  input  logic [1:0]  wr_sel,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  output logic [31:0] ld_data
);
  logic [15:0] v;
  assign v = 16'(rdata >> {a, 3'b000});
  assign mem_wdata = wr_sel == WR_SB ? {4{wdata[7:0]}} :
                     wr_sel == WR_SH ? {2{wdata[15:0]}} :
                     wr_sel == WR_SW ? wdata : '0;
  assign mem_wmask = wr_sel == WR_SB ? 4'b0001 << a :
                     wr_sel == WR_SH ? 4'b0011 << a :
                     wr_sel == WR_SW ? 4'b1111 : 4'b0000;
  assign ld_data = rd_sel == RD_LB  ? {{24{v[7]}}, v[7:0]} :
                   rd_sel == RD_LBU ? {24'b0, v[7:0]} :
                   rd_sel == RD_LH  ? {{16{v[15]}}, v[15:0]} :
                   rd_sel == RD_LHU ? {16'b0, v[15:0]} :
                   rd_sel == RD_LW  ? rdata : '0;
endmodule

// File: rtl/ysyx_lsu.sv
// ysyx_lsu: multi-cycle load/store unit on a word-aligned req/gnt/rvalid bus
module ysyx_lsu import ysyx_lsu_pkg::*; #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [2:0]  in_rd_sel,
  input  logic [1:0]  in_wr_sel,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rdata,
  output logic        out_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);
  state_e state, state_nx;
  logic [31:0] addr_q, wdata_q, rdata_q, ld_data;
  logic [2:0] rd_q;
  logic [1:0] wr_q;
  logic [TO_W-1:0] cnt;
  logic err_q, acc, busy, bad, skip, done, tmo;
  assign acc  = state == S_IDLE && in_valid;
  assign busy = state == S_REQ || state == S_WAIT;
  assign bad  = (in_rd_sel != RD_NONE && in_wr_sel != WR_NONE) || is_mis(in_rd_sel, in_wr_sel, in_addr[1:0]);
  assign skip = bad || (in_rd_sel == RD_NONE && in_wr_sel == WR_NONE);
  assign done = (state == S_REQ && mem_gnt && mem_rvalid) || (state == S_WAIT && mem_rvalid);
  assign tmo  = busy && cnt == TO_W'(TIMEOUT - 1) && !done;
  assign in_ready  = state == S_IDLE;
  assign out_valid = state == S_RESP;
  assign out_rdata = rdata_q;
  assign out_err   = err_q;
  assign mem_req   = state == S_REQ;
  assign mem_we    = wr_q != WR_NONE;
  assign mem_addr  = {addr_q[31:2], 2'b00};
  ysyx_lsu_align u_align (
    .a         (addr_q[1:0]),
    .rd_sel    (rd_q),
    .wr_sel    (wr_q),
    .wdata     (wdata_q),
    .rdata     (mem_rdata),
    .mem_wdata (mem_wdata),
    .mem_wmask (mem_wmask),
    .ld_data   (ld_data)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: state_nx = in_valid ? (skip ? S_RESP : S_REQ) : S_IDLE;
      S_REQ:  state_nx = done || tmo ? S_RESP : mem_gnt ? S_WAIT : S_REQ;
      S_WAIT: state_nx = done || tmo ? S_RESP : S_WAIT;
      S_RESP: state_nx = out_ready ? S_IDLE : S_RESP;
      default: state_nx = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= RD_NONE;
      wr_q    <= WR_NONE;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt     <= '0;
    end else if (acc) begin
      addr_q  <= in_addr;
      wdata_q <= in_wdata;
      rd_q    <= in_rd_sel;
      wr_q    <= in_wr_sel;
      rdata_q <= '0;
      err_q   <= bad;
      cnt     <= '0;
    end else if (busy) begin
      cnt <= cnt + TO_W'(1);
      if (done) rdata_q <= ld_data;
      else if (tmo) err_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ysyx_lsu.sv
// tb_ysyx_lsu: directed self-checking bench for ysyx_lsu with a short timeout
module tb_ysyx_lsu;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, out_err;
  logic [31:0] in_addr = '0, in_wdata = '0, out_rdata, mem_addr, mem_wdata, mem_rdata = '0;
  logic [2:0] in_rd_sel = '0;
  logic [1:0] in_wr_sel = '0;
  logic mem_req, mem_we, mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [3:0] mem_wmask;
  int checks = 0, errors = 0, n;
  ysyx_lsu #(.TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_rd_sel(in_rd_sel), .in_wr_sel(in_wr_sel),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_err(out_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic issue(input logic [2:0] rd, input logic [1:0] wr, input logic [31:0] a, input logic [31:0] d);
    in_valid = 1'b1; in_rd_sel = rd; in_wr_sel = wr; in_addr = a; in_wdata = d;
    check("accept_ready", in_ready, 1);
    tick();
    in_valid = 1'b0; in_rd_sel = '0; in_wr_sel = '0;
  endtask
  task automatic bus_now(input logic [31:0] w);
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = w;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
  endtask
  task automatic result(input string tag, input logic [31:0] r, input logic e);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_rdata"}, out_rdata, r);
    check({tag, "_err"}, out_err, e);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_idle"}, in_ready, 1);
  endtask
  initial begin
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_wmask", mem_wmask, 0);
    rst_n = 1'b1;
    tick();
    issue(3'b000, 2'b11, 32'h8000_0004, 32'hDEAD_BEEF);
    check("sw_req", mem_req, 1);
    check("sw_we", mem_we, 1);
    check("sw_addr", mem_addr, 32'h8000_0004);
    check("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
    check("sw_wmask", mem_wmask, 4'b1111);
    check("sw_not_yet", out_valid, 0);
    bus_now(32'h0);
    result("sw", 32'h0, 0);
    issue(3'b001, 2'b00, 32'h8000_0000, 0);
    check("lb_we", mem_we, 0);
    check("lb_wmask", mem_wmask, 0);
    bus_now(32'h8077_F0AA);
    result("lb", 32'hFFFF_FFAA, 0);
    issue(3'b100, 2'b00, 32'h8000_0003, 0);
    check("lbu_addr", mem_addr, 32'h8000_0000);
    bus_now(32'h8077_F0AA);
    result("lbu", 32'h0000_0080, 0);
    issue(3'b010, 2'b00, 32'h8000_0002, 0);
    bus_now(32'h8077_F0AA);
    result("lh", 32'hFFFF_8077, 0);
    issue(3'b101, 2'b00, 32'h8000_0002, 0);
    bus_now(32'h8077_F0AA);
    result("lhu", 32'h0000_8077, 0);
    issue(3'b011, 2'b00, 32'h8000_0000, 0);
    bus_now(32'h8077_F0AA);
    result("lw", 32'h8077_F0AA, 0);
    issue(3'b000, 2'b01, 32'h8000_0001, 32'h1234_5678);
    check("sb_wdata", mem_wdata, 32'h7878_7878);
    check("sb_wmask", mem_wmask, 4'b0010);
    bus_now(0);
    result("sb", 0, 0);
    issue(3'b000, 2'b10, 32'h8000_0002, 32'h1234_5678);
    check("sh_wdata", mem_wdata, 32'h5678_5678);
    check("sh_wmask", mem_wmask, 4'b1100);
    bus_now(0);
    result("sh", 0, 0);
    issue(3'b000, 2'b10, 32'h8000_0003, 32'h1234_5678);
    check("mis_req", mem_req, 0);
    result("mis", 0, 1);
    issue(3'b001, 2'b11, 32'h8000_0000, 32'h1);
    check("ill_req", mem_req, 0);
    result("ill", 0, 1);
    issue(3'b000, 2'b00, 32'h8000_0000, 32'h1);
    check("none_req", mem_req, 0);
    result("none", 0, 0);
    issue(3'b011, 2'b00, 32'h8000_0008, 0);
    n = 0;
    for (int i = 0; i < 20 && mem_req; i++) begin
      n++;
      tick();
    end
    check("to_req_cycles", n, 8);
    check("to_valid", out_valid, 1);
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    mem_rvalid = 1'b0;
    check("to_busy", in_ready, 0);
    result("to", 0, 1);
    issue(3'b011, 2'b00, 32'h8000_0010, 0);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    check("w_req_drop", mem_req, 0);
    for (int i = 0; i < 3; i++) begin
      check("w_wait_ready", in_ready, 0);
      check("w_wait_valid", out_valid, 0);
      tick();
    end
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_rvalid = 1'b0; mem_rdata = '0;
    for (int i = 0; i < 3; i++) begin
      check("w_hold_valid", out_valid, 1);
      check("w_hold_rdata", out_rdata, 32'hCAFE_F00D);
      check("w_hold_ready", in_ready, 0);
      tick();
    end
    result("w", 32'hCAFE_F00D, 0);
    issue(3'b011, 2'b00, 32'h8000_0020, 0);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    check("r_in_wait", in_ready, 0);
    rst_n = 1'b0;
    #1;
    check("r_req", mem_req, 0);
    check("r_valid", out_valid, 0);
    check("r_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
    tick();
    mem_rvalid = 1'b0;
    check("r_late_valid", out_valid, 0);
    check("r_late_ready", in_ready, 1);
    check("r_late_rdata", out_rdata, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
